// File: rtl/foxtrot_pkg.sv
// Shared result-bus types and default widths for the foxtrot backend.
package foxtrot_pkg;

  localparam int PRN_BITS     = 6;
  localparam int INST_ID_BITS = 6;

  typedef struct packed {
    logic [INST_ID_BITS-1:0] inst_id;
    logic [PRN_BITS-1:0]     prn;
    logic [63:0]             value;
  } result_t;

endpackage

// File: rtl/result_fifo.sv
// Small per-FU result FIFO; head entry is always visible on dout.
module result_fifo
  import foxtrot_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  result_t din,
  output result_t dout,
  output logic    empty,
  output logic    full
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  result_t             mem_q [DEPTH];
  result_t             mem_d [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_BITS'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_BITS'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_BITS'(DEPTH));

endmodule

// File: rtl/result_broadcast_arbiter.sv
// Serialises FU results onto the single result bus: per-FU FIFOs, a round-robin
// pick over non-empty heads, and a registered broadcast stage.
module result_broadcast_arbiter #(
  parameter int NUM_FUS      = 4,
  parameter int PRN_BITS     = foxtrot_pkg::PRN_BITS,
  parameter int INST_ID_BITS = foxtrot_pkg::INST_ID_BITS,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_FUS-1:0]      fu_valid,
  output logic [NUM_FUS-1:0]      fu_ready,
  input  logic [PRN_BITS-1:0]     fu_prn     [NUM_FUS],
  input  logic [63:0]             fu_value   [NUM_FUS],
  input  logic [INST_ID_BITS-1:0] fu_inst_id [NUM_FUS],
  output logic                    result_valid,
  output logic [PRN_BITS-1:0]     result_prn,
  output logic [63:0]             result_value,
  output logic [INST_ID_BITS-1:0] result_inst_id
);

  import foxtrot_pkg::*;

  localparam int RR_BITS = $clog2(NUM_FUS);

  logic [NUM_FUS-1:0] fifo_push, fifo_pop, fifo_empty, fifo_full;
  result_t            fifo_din  [NUM_FUS];
  result_t            fifo_dout [NUM_FUS];

  logic [RR_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [RR_BITS-1:0] grant_idx;
  logic               any_grant;
  logic               result_valid_q, result_valid_d;
  result_t            result_q, result_d;

  // Ready comes from registered occupancy only, so a full FIFO that pops this
  // cycle still refuses the incoming beat; pushes while not ready are dropped.
  assign fu_ready  = ~fifo_full;
  assign fifo_push = fu_valid & fu_ready;

  for (genvar i = 0; i < NUM_FUS; i++) begin : g_fu
    always_comb begin
      fifo_din[i]         = '0;
      fifo_din[i].inst_id = fu_inst_id[i];
      fifo_din[i].prn     = fu_prn[i];
      fifo_din[i].value   = fu_value[i];
    end

    result_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push[i]),
      .pop   (fifo_pop[i]),
      .din   (fifo_din[i]),
      .dout  (fifo_dout[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i])
    );
  end

  // Scan starting at rr_ptr and wrapping; first non-empty FIFO wins.
  always_comb begin : arb
    int idx;
    idx       = 0;
    any_grant = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_FUS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_FUS;
      if (!any_grant && !fifo_empty[idx]) begin
        any_grant = 1'b1;
        grant_idx = RR_BITS'(idx);
      end
    end

    fifo_pop = '0;
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      fifo_pop[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == RR_BITS'(NUM_FUS - 1)) ? '0 : grant_idx + RR_BITS'(1);
    end
  end

  always_comb begin
    result_valid_d = any_grant;
    result_d       = any_grant ? fifo_dout[grant_idx] : result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
    end
  end

  assign result_valid   = result_valid_q;
  assign result_prn     = result_q.prn;
  assign result_value   = result_q.value;
  assign result_inst_id = result_q.inst_id;

endmodule

// File: tb/tb_result_broadcast_arbiter.sv
// Randomised and directed bench for result_broadcast_arbiter against a queue-based model.
module tb_result_broadcast_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  fu_valid = '0;
  logic [3:0]  fu_ready;
  logic [5:0]  fu_prn     [4];
  logic [63:0] fu_value   [4];
  logic [5:0]  fu_inst_id [4];
  logic        result_valid;
  logic [5:0]  result_prn;
  logic [63:0] result_value;
  logic [5:0]  result_inst_id;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: one queue per FU holding {inst_id, prn, value}, plus the rotating start index.
  logic [75:0] mq [4][$];
  int          rr        = 0;
  logic        exp_valid = 1'b0;
  logic [75:0] exp_pay   = '0;

  always #5 clk = ~clk;

  result_broadcast_arbiter #(
    .NUM_FUS      (4),
    .PRN_BITS     (6),
    .INST_ID_BITS (6),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fu_valid       (fu_valid),
    .fu_ready       (fu_ready),
    .fu_prn         (fu_prn),
    .fu_value       (fu_value),
    .fu_inst_id     (fu_inst_id),
    .result_valid   (result_valid),
    .result_prn     (result_prn),
    .result_value   (result_value),
    .result_inst_id (result_inst_id)
  );

  always @(posedge clk) begin
    if (!rst && ((fu_valid & ~fu_ready) != 4'b0))
      $error("[TB] protocol violation fu_valid=%b fu_ready=%b", fu_valid, fu_ready);
  end

  function automatic logic [76:0] bus_obs();
    return {result_valid, result_inst_id, result_prn, result_value};
  endfunction

  function automatic logic [76:0] bus_exp();
    return {exp_valid, exp_pay};
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 2);
    return r;
  endfunction

  // One clock edge; the model applies the same edge, then we park on the falling edge.
  task automatic tick();
    logic [3:0] rdy;
    int g;
    int idx;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      rr        = 0;
      exp_valid = 1'b0;
      exp_pay   = '0;
    end else begin
      rdy = exp_ready();
      g   = -1;
      for (int k = 0; k < 4; k++) begin
        idx = (rr + k) % 4;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      exp_valid = (g >= 0);
      if (g >= 0) begin
        exp_pay = mq[g].pop_front();
        rr      = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (fu_valid[i] && rdy[i]) mq[i].push_back({fu_inst_id[i], fu_prn[i], fu_value[i]});
    end
    @(negedge clk);
  endtask

  // Present a result on FU i, asserting valid only while the FIFO can take it.
  task automatic offer(input int i, input logic [5:0] prn, input logic [63:0] v, input logic [5:0] id);
    fu_prn[i]     = prn;
    fu_value[i]   = v;
    fu_inst_id[i] = id;
    fu_valid[i]   = (mq[i].size() != 2);
  endtask

  task automatic do_reset();
    fu_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fu_valid = '0;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus_obs() !== 77'd0) $display("[TB] FAIL reset_bus got=%h exp=0", bus_obs());
    else n_pass++;
    n_checks++;
    if (fu_ready !== 4'hF) $display("[TB] FAIL reset_ready got=%b exp=1111", fu_ready);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_push();
    do_reset();
    offer(2, 6'd5, 64'hDEAD, 6'd9);
    tick();
    fu_valid = '0;
    n_checks++;
    if (result_valid !== 1'b0) $display("[TB] FAIL single_early got=%b exp=0", result_valid);
    else n_pass++;
    n_checks++;
    if (fu_ready !== 4'hF) $display("[TB] FAIL single_ready1 got=%b exp=1111", fu_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus_obs() !== {1'b1, 6'd9, 6'd5, 64'hDEAD})
      $display("[TB] FAIL single_beat got=%h exp=%h", bus_obs(), {1'b1, 6'd9, 6'd5, 64'hDEAD});
    else n_pass++;
    n_checks++;
    if (fu_ready !== 4'hF) $display("[TB] FAIL single_ready2 got=%b exp=1111", fu_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (result_valid !== 1'b0) $display("[TB] FAIL single_after got=%b exp=0", result_valid);
    else n_pass++;
  endtask

  task automatic test_all_fus();
    do_reset();
    for (int i = 0; i < 4; i++) offer(i, 6'(i), {$urandom, $urandom}, 6'(40 + i));
    tick();
    fu_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (result_valid !== 1'b1 || result_prn !== 6'(k))
        $display("[TB] FAIL allfu_order valid=%b prn=%0d exp prn=%0d", result_valid, result_prn, k);
      else n_pass++;
      n_checks++;
      if (bus_obs() !== bus_exp()) $display("[TB] FAIL allfu_bus got=%h exp=%h", bus_obs(), bus_exp());
      else n_pass++;
    end
    n_checks++;
    if (dut.rr_ptr_q !== 2'd0) $display("[TB] FAIL allfu_rr got=%0d exp=0", dut.rr_ptr_q);
    else n_pass++;
    tick();
    n_checks++;
    if (result_valid !== 1'b0) $display("[TB] FAIL allfu_drop got=%b exp=0", result_valid);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int seq0;
    int seq1;
    logic [5:0] seen [$];
    logic [5:0] fu1_ids [$];
    seq0 = 0;
    seq1 = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      offer(0, 6'($urandom), {$urandom, $urandom}, {2'd0, 4'(seq0)});
      if (fu_valid[0]) seq0++;
      if (seq1 < 3) begin
        offer(1, 6'($urandom), {$urandom, $urandom}, {2'd1, 4'(seq1)});
        if (fu_valid[1]) seq1++;
      end else fu_valid[1] = 1'b0;
      tick();
      n_checks++;
      if (bus_obs() !== bus_exp()) $display("[TB] FAIL alt_bus got=%h exp=%h", bus_obs(), bus_exp());
      else n_pass++;
      if (result_valid) begin
        seen.push_back(result_inst_id);
        if (result_inst_id[5:4] == 2'd1) fu1_ids.push_back(result_inst_id);
      end
    end
    fu_valid = '0;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (k >= seen.size() || seen[k][5:4] !== 2'(k % 2))
        $display("[TB] FAIL alt_turn beat=%0d got_fu=%0d exp_fu=%0d", k,
                 (k < seen.size()) ? int'(seen[k][5:4]) : -1, k % 2);
      else n_pass++;
    end
    n_checks++;
    if (fu1_ids.size() != 3 || fu1_ids[0] !== 6'd16 || fu1_ids[1] !== 6'd17 || fu1_ids[2] !== 6'd18)
      $display("[TB] FAIL alt_fu1_order got_count=%0d exp=3 (ids 16,17,18)", fu1_ids.size());
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_full_fifo();
    int seq3;
    bit saw_not_ready;
    bit first_seen;
    logic [5:0] fu3_ids [$];
    seq3 = 0;
    saw_not_ready = 1'b0;
    first_seen = 1'b0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) offer(i, 6'($urandom), {$urandom, $urandom}, {2'(i), 4'(c)});
      if (seq3 < 2) begin
        offer(3, 6'(50 + seq3), {$urandom, $urandom}, {2'd3, 4'(seq3)});
        if (fu_valid[3]) seq3++;
      end else fu_valid[3] = 1'b0;
      tick();
      n_checks++;
      if (bus_obs() !== bus_exp()) $display("[TB] FAIL full_bus got=%h exp=%h", bus_obs(), bus_exp());
      else n_pass++;
      n_checks++;
      if (fu_ready !== exp_ready()) $display("[TB] FAIL full_ready got=%b exp=%b", fu_ready, exp_ready());
      else n_pass++;
      if (fu_ready[3] === 1'b0) saw_not_ready = 1'b1;
      if (result_valid && result_inst_id[5:4] == 2'd3) begin
        fu3_ids.push_back(result_inst_id);
        if (!first_seen) begin
          first_seen = 1'b1;
          n_checks++;
          if (fu_ready[3] !== 1'b1) $display("[TB] FAIL full_ready_return got=%b exp=1", fu_ready[3]);
          else n_pass++;
        end
      end
    end
    fu_valid = '0;
    n_checks++;
    if (saw_not_ready !== 1'b1) $display("[TB] FAIL full_not_ready got=%b exp=1", saw_not_ready);
    else n_pass++;
    n_checks++;
    if (fu3_ids.size() != 2 || fu3_ids[0] !== 6'd48 || fu3_ids[1] !== 6'd49)
      $display("[TB] FAIL full_fu3_entries got_count=%0d exp=2 (ids 48,49)", fu3_ids.size());
    else n_pass++;
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    offer(0, 6'd0, 64'h1000, 6'd0);
    tick();
    for (int c = 0; c < 10; c++) begin
      offer(0, 6'(c + 1), 64'h1000 + 64'(c + 1), 6'(c + 1));
      tick();
      n_checks++;
      if (fu_ready[0] !== 1'b1) $display("[TB] FAIL pp_ready cycle=%0d got=%b exp=1", c, fu_ready[0]);
      else n_pass++;
      n_checks++;
      if (result_valid !== 1'b1 || result_value !== 64'h1000 + 64'(c))
        $display("[TB] FAIL pp_value cycle=%0d valid=%b got=%h exp=%h", c, result_valid, result_value,
                 64'h1000 + 64'(c));
      else n_pass++;
    end
    fu_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) offer(i, 6'(i), {$urandom, $urandom}, 6'(i));
    tick();
    fu_valid = '0;
    offer(1, 6'd11, 64'h11, 6'd11);
    offer(2, 6'd12, 64'h12, 6'd12);
    tick();
    fu_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0) $display("[TB] FAIL rstmid_valid got=%b exp=0", result_valid);
    else n_pass++;
    n_checks++;
    if (fu_ready !== 4'hF) $display("[TB] FAIL rstmid_ready got=%b exp=1111", fu_ready);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (result_valid !== 1'b0) $display("[TB] FAIL rstmid_stale cycle=%0d got=%b exp=0", c, result_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 99) < 60)
          offer(i, 6'($urandom), {$urandom, $urandom}, 6'($urandom));
        else fu_valid[i] = 1'b0;
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
      n_checks++;
      if (bus_obs() !== bus_exp()) $display("[TB] FAIL rand_bus cycle=%0d got=%h exp=%h", c, bus_obs(), bus_exp());
      else n_pass++;
      n_checks++;
      if (fu_ready !== exp_ready()) $display("[TB] FAIL rand_ready cycle=%0d got=%b exp=%b", c, fu_ready, exp_ready());
      else n_pass++;
    end
    rst = 1'b0;
    fu_valid = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      fu_prn[i]     = '0;
      fu_value[i]   = '0;
      fu_inst_id[i] = '0;
    end
    test_reset();
    test_single_push();
    test_all_fus();
    test_alternate();
    test_full_fifo();
    test_simul_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
